apb_dma_mem_slave: RTL and testbench

- APB slave word memory. Sits directly downstream of the Ethernet core's APB master port (the m_* DMA bus) and serves the core's buffer-descriptor and frame-data fetches and stores.
- Provides programmable fixed or pseudo-random wait states through pready_o, so the DMA path can be exercised under back-pressure.
- Synthesizable single-port RAM model. One clock domain: the APB clock.

---
 rtl/apb_dma_mem_slave.sv | 102 ++++++++++
 tb/tb_apb_dma_mem_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apb_dma_mem_slave.sv
// apb_dma_mem_slave: APB slave word RAM with fixed or LFSR-driven wait states for the DMA bus.
// Out-of-range accesses complete normally, drop writes and read back zero.
module apb_dma_mem_slave #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_MODE = 0,
    parameter int          RD_WAIT   = 0,
    parameter int          WR_WAIT   = 0,
    parameter int          MAX_WAIT  = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        pclk_i,
    input  logic        prstn_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic        psel_i,
    input  logic        pwrite_i,
    input  logic        penable_i,
    output logic [31:0] prdata_o,
    output logic        pready_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [31:2] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  cnt;
    logic [7:0]  lfsr;
    logic [3:0]  rnd_wait;
    logic [3:0]  wait_sel;
    logic        setup;
    logic        done;

    function automatic logic in_range(input logic [31:2] a);
        return a[31:AW+2] == BASE_ADDR[31:AW+2];
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:2] a);
        return in_range(a) ? mem[a[AW+1:2]] : 32'h0;
    endfunction

    assign rnd_wait = (lfsr[3:0] > 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : lfsr[3:0];
    assign wait_sel = (WAIT_MODE != 0) ? rnd_wait : (pwrite_i ? 4'(WR_WAIT) : 4'(RD_WAIT));
    assign setup    = (state == IDLE) && psel_i && !penable_i;
    assign done     = (state == ACCESS) && psel_i && penable_i && pready_o;

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            state    <= IDLE;
            addr     <= '0;
            write    <= 1'b0;
            wdata    <= '0;
            cnt      <= '0;
            lfsr     <= LFSR_SEED;
            pready_o <= 1'b0;
            prdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state    <= ACCESS;
                        addr     <= paddr_i[31:2];
                        write    <= pwrite_i;
                        wdata    <= pwdata_i;
                        cnt      <= wait_sel;
                        pready_o <= (wait_sel == 4'd0);
                        lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        if (wait_sel == 4'd0 && !pwrite_i)
                            prdata_o <= rd_word(paddr_i[31:2]);
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state    <= IDLE;
                        pready_o <= 1'b0;
                    end else if (pready_o) begin
                        if (penable_i) begin
                            state    <= IDLE;
                            pready_o <= 1'b0;
                        end
                    end else begin
                        cnt      <= cnt - 4'd1;
                        pready_o <= (cnt == 4'd1);
                        if (cnt == 4'd1 && !write)
                            prdata_o <= rd_word(addr);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM has no reset so its contents survive prstn_i.
    always_ff @(posedge pclk_i) begin
        if (done && write && in_range(addr))
            mem[addr[AW+1:2]] <= wdata;
    end
endmodule

// File: tb/tb_apb_dma_mem_slave.sv
// tb_apb_dma_mem_slave: directed vectors for apb_dma_mem_slave across four wait-state configurations.
module tb_apb_dma_mem_slave;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic [3:0]  psel = '0;
    logic [31:0] prdata [4];
    logic        pready [4];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    apb_dma_mem_slave #(.RD_WAIT(0), .WR_WAIT(0)) d0 (
        .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .pwdata_i(pwdata), .psel_i(psel[0]),
        .pwrite_i(pwrite), .penable_i(penable), .prdata_o(prdata[0]), .pready_o(pready[0]));
    apb_dma_mem_slave #(.RD_WAIT(3), .WR_WAIT(2)) d1 (
        .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .pwdata_i(pwdata), .psel_i(psel[1]),
        .pwrite_i(pwrite), .penable_i(penable), .prdata_o(prdata[1]), .pready_o(pready[1]));
    apb_dma_mem_slave #(.WAIT_MODE(1), .MAX_WAIT(3), .LFSR_SEED(8'hA5)) d2 (
        .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .pwdata_i(pwdata), .psel_i(psel[2]),
        .pwrite_i(pwrite), .penable_i(penable), .prdata_o(prdata[2]), .pready_o(pready[2]));
    apb_dma_mem_slave #(.RD_WAIT(3), .WR_WAIT(3)) d3 (
        .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .pwdata_i(pwdata), .psel_i(psel[3]),
        .pwrite_i(pwrite), .penable_i(penable), .prdata_o(prdata[3]), .pready_o(pready[3]));

    typedef struct {
        int          dev;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts at posedge+1, returns at posedge+1 just after the completion edge.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int w);
        paddr   = a;
        pwdata  = wd;
        pwrite  = wr;
        psel[d] = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        w = 0;
        while (pready[d] !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 40) begin
            fails++;
            $display("FAIL timeout: dev %0d never raised pready, expected within 40 cycles", d);
        end
        rd = prdata[d];
        @(posedge clk); #1;
        psel[d] = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        int          ew;
        logic [7:0]  lf;
        time         t0;
        time         t1;

        tbl.push_back(vec_t'{0, 1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 0});
        tbl.push_back(vec_t'{1, 1'b1, 32'h10,   32'h12345678, 32'h0,        2});
        tbl.push_back(vec_t'{1, 1'b0, 32'h10,   32'h0,        32'h12345678, 3});
        tbl.push_back(vec_t'{0, 1'b1, 32'h0,    32'hAAAA0000, 32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h1000, 32'h0,        32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b1, 32'h1000, 32'h5,        32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h0,    32'h0,        32'hAAAA0000, 0});
        tbl.push_back(vec_t'{0, 1'b1, 32'h0,    32'h1,        32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b1, 32'h4,    32'h2,        32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b1, 32'h8,    32'h3,        32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b1, 32'hC,    32'h4,        32'h0,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h0,    32'h0,        32'h1,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h4,    32'h0,        32'h2,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h8,    32'h0,        32'h3,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'hC,    32'h0,        32'h4,        0});
        tbl.push_back(vec_t'{0, 1'b0, 32'h7,    32'h0,        32'h2,        0});
        tbl.push_back(vec_t'{1, 1'b0, 32'h1004, 32'h0,        32'h0,        3});

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset pready d%0d", i), {31'h0, pready[i]}, 32'h0);
            chk($sformatf("reset prdata d%0d", i), prdata[i], 32'h0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        t0 = 0;
        t1 = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 8) t0 = $time;
            if (i == 16) t1 = $time;
            xfer(tbl[i].dev, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, w);
            chk($sformatf("vec%0d waits", i), w, tbl[i].waits);
            if (!tbl[i].wr) chk($sformatf("vec%0d rdata", i), rd, tbl[i].rdata);
        end
        chk("back-to-back cycles", 32'((t1 - t0) / 10), 32'd16);

        // penable without a setup phase must be ignored
        psel[0] = 1'b1;
        penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("no-setup pready %0d", i), {31'h0, pready[0]}, 32'h0);
        end
        psel[0] = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;

        // abort mid-wait drops the write
        xfer(1, 1'b1, 32'h40, 32'h11111111, rd, w);
        paddr   = 32'h40;
        pwdata  = 32'h00000BAD;
        pwrite  = 1'b1;
        psel[1] = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        chk("abort pready", {31'h0, pready[1]}, 32'h0);
        @(posedge clk); #1;
        chk("abort pready late", {31'h0, pready[1]}, 32'h0);
        xfer(1, 1'b0, 32'h40, 32'h0, rd, w);
        chk("abort readback", rd, 32'h11111111);
        chk("abort readback waits", w, 32'd3);

        lf = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            ew = (lf[3:0] > 4'd3) ? 3 : int'(lf[3:0]);
            xfer(2, 1'b0, 32'(i * 4), 32'h0, rd, w);
            chk($sformatf("lfsr waits %0d", i), w, ew);
            chk($sformatf("lfsr clip %0d", i), {31'h0, w <= 3}, 32'h1);
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end

        // reset in the middle of a write wait
        xfer(3, 1'b1, 32'h20, 32'hCAFEF00D, rd, w);
        chk("d3 write waits", w, 32'd3);
        xfer(3, 1'b0, 32'h20, 32'h0, rd, w);
        chk("d3 pre-reset read", rd, 32'hCAFEF00D);
        paddr   = 32'h20;
        pwdata  = 32'h0BADBEEF;
        pwrite  = 1'b1;
        psel[3] = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("midreset pready", {31'h0, pready[3]}, 32'h0);
        chk("midreset prdata d3", prdata[3], 32'h0);
        chk("midreset prdata d1", prdata[1], 32'h0);
        psel[3] = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        xfer(3, 1'b0, 32'h20, 32'h0, rd, w);
        chk("post-reset read", rd, 32'hCAFEF00D);
        chk("post-reset read waits", w, 32'd3);
        xfer(2, 1'b0, 32'h0, 32'h0, rd, w);
        chk("lfsr reseeded waits", w, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end
endmodule
